// File: rtl/aes_128_key_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_key_scheduler_pkg
// Description : Shared constants for the AES-128 key scheduler: FSM state
//               encoding, round count, key width and the Rcon table.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_128_key_scheduler_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    // Round constants for rounds 1..10; round 1 occupies the top byte.
    localparam logic [8*NR-1:0] RCON_TABLE = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Rcon byte for a round number 1..10; zero for anything else.
    function automatic logic [7:0] rcon_of(input logic [3:0] round);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 1; i <= NR; i++) begin
            if (round == i[3:0]) begin
                r = RCON_TABLE[(NR - i) * 8 +: 8];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : AES forward S-box, 8-bit combinational table lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] sel,
    output logic [7:0] sub
);

    // Entry 0x00 is the most significant byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte n sits at bit offset (255 - n) * 8, and 255 - n is simply ~n.
    logic [10:0] bit_ofs;
    assign bit_ofs = {~sel, 3'b000};
    assign sub     = SBOX_TABLE[bit_ofs +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_128_key_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_key_scheduler
// Description : AES-128 key expansion into an 11-entry round-key file, one
//               round per cycle, then streams rk0..rk10 over a valid/ready
//               interface in decryption (DEC_ORDER=1) or encryption order.
//               Optional macro AES_KEY_CACHE_EN: reuse the last fully
//               expanded schedule when the same key is requested again.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_128_key_scheduler
    import aes_128_key_scheduler_pkg::*;
#(
    parameter int DEC_ORDER = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_data,
    output logic [3:0]       rk_idx,
    output logic             done
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [3:0] FIRST_IDX  = (DEC_ORDER != 0) ? LAST_ROUND : 4'd0;
    localparam logic [3:0] LAST_IDX   = (DEC_ORDER != 0) ? 4'd0 : LAST_ROUND;

    logic [1:0]       state;
    logic [3:0]       rnd;        // round being computed during EXPAND
    logic [3:0]       ptr;        // round key presented during STREAM
    logic [KEY_W-1:0] cur_key;    // most recent round key, feeds next round
    logic [KEY_W-1:0] rf [0:NR];
    logic             cache_hit;
    logic             accept_new; // start accepted and a full expansion needed

    // ------------------------------------------------------------------
    // One FIPS-197 key-expansion round
    // ------------------------------------------------------------------
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_word, sub_word, temp_word;
    logic [31:0] n0, n1, n2, n3;
    logic [KEY_W-1:0] next_key;

    assign {w0, w1, w2, w3} = cur_key;
    assign rot_word         = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .sel (rot_word[8*g +: 8]),
            .sub (sub_word[8*g +: 8])
        );
    end

    assign temp_word = sub_word ^ {rcon_of(rnd), 24'h000000};
    assign n0        = w0 ^ temp_word;
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign next_key  = {n0, n1, n2, n3};

    assign accept_new = (state == ST_IDLE) && start && !cache_hit;

    // ------------------------------------------------------------------
    // Schedule cache: rf[0] already holds the key of the last expansion,
    // so only a validity flag is needed to recognise a repeated key.
    // ------------------------------------------------------------------
`ifdef AES_KEY_CACHE_EN
    logic cache_valid;

    // Valid once a full expansion finishes; dropped when a new one begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
        end else if (accept_new) begin
            cache_valid <= 1'b0;
        end else if ((state == ST_EXPAND) && (rnd == LAST_ROUND)) begin
            cache_valid <= 1'b1;
        end
    end

    assign cache_hit = cache_valid && (key == rf[0]);
`else
    assign cache_hit = 1'b0;
`endif

    // Control FSM: IDLE -> EXPAND (10 rounds) -> STREAM (11 beats) -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rnd     <= 4'd0;
            ptr     <= 4'd0;
            cur_key <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cache_hit) begin
                            state <= ST_STREAM;
                            ptr   <= FIRST_IDX;
                        end else begin
                            state   <= ST_EXPAND;
                            rnd     <= 4'd1;
                            cur_key <= key;
                        end
                    end
                end
                ST_EXPAND: begin
                    cur_key <= next_key;
                    if (rnd == LAST_ROUND) begin
                        state <= ST_STREAM;
                        ptr   <= FIRST_IDX;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ST_STREAM: begin
                    if (rk_ready) begin
                        if (ptr == LAST_IDX) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else if (DEC_ORDER != 0) begin
                            ptr <= ptr - 4'd1;
                        end else begin
                            ptr <= ptr + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Round-key file: key lands in rf[0] on start, then one round per cycle
    always_ff @(posedge clk) begin
        if (accept_new) begin
            rf[0] <= key;
        end else if (state == ST_EXPAND) begin
            rf[rnd] <= next_key;
        end
    end

    assign busy     = (state != ST_IDLE);
    assign rk_valid = (state == ST_STREAM);
    assign rk_data  = rk_valid ? rf[ptr] : '0;
    assign rk_idx   = rk_valid ? ptr : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_aes_128_key_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_128_key_scheduler
// Description : Self-checking bench for aes_128_key_scheduler. Two instances
//               (decryption and encryption order) share all inputs and are
//               checked against a key-expansion model built from GF(2^8)
//               arithmetic. Honours AES_KEY_CACHE_EN for latency checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_128_key_scheduler;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         start    = 1'b0;
    logic         rk_ready = 1'b0;
    logic [127:0] key      = '0;

    logic         busy_d, valid_d, done_d, busy_e, valid_e, done_e;
    logic [127:0] data_d, data_e;
    logic [3:0]   idx_d, idx_e;

    always #5 clk = ~clk;

    aes_128_key_scheduler #(.DEC_ORDER(1)) u_dec (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key),
        .busy(busy_d), .rk_valid(valid_d), .rk_ready(rk_ready),
        .rk_data(data_d), .rk_idx(idx_d), .done(done_d)
    );

    aes_128_key_scheduler #(.DEC_ORDER(0)) u_enc (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key),
        .busy(busy_e), .rk_valid(valid_e), .rk_ready(rk_ready),
        .rk_data(data_e), .rk_idx(idx_e), .done(done_e)
    );

`ifdef AES_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   sbox_m [256];
    logic [127:0] ref_rk [11];
    logic [127:0] got [2][11];
    bit           cache_ok  = 1'b0;
    logic [127:0] cache_key = '0;

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from multiplicative inverse plus affine transform
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-wise FIPS-197 expansion into 44 words
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Start an expansion at the current negedge and follow it to done.
    // glitch > 0: pulse start with another key at that cycle and keep key changed.
    task automatic run_schedule(input logic [127:0] k, input bit rand_ready,
                                input int glitch, input string tag);
        int           exp_lat, cyc;
        int           first [2], done_cyc [2], beats [2];
        bit           stall [2];
        logic [127:0] pdata [2];
        logic [3:0]   pidx [2];
        logic         vv [2], dn [2], bz [2];
        logic [127:0] dd [2];
        logic [3:0]   ii [2];
        int           exp_idx;
        model_expand(k);
        exp_lat = (CACHE_EN && cache_ok && (cache_key == k)) ? 1 : 11;
        for (int u = 0; u < 2; u++) begin
            first[u] = -1; done_cyc[u] = -1; beats[u] = 0; stall[u] = 1'b0;
            pdata[u] = '0; pidx[u] = '0;
        end
        start    = 1'b1;
        key      = k;
        rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        for (cyc = 1; cyc <= 200 && (done_cyc[0] < 0 || done_cyc[1] < 0); cyc++) begin
            @(negedge clk);
            start = (cyc == glitch);
            if (glitch > 0 && cyc >= glitch) key = ~k;
            vv[0] = valid_d; dd[0] = data_d; ii[0] = idx_d; dn[0] = done_d; bz[0] = busy_d;
            vv[1] = valid_e; dd[1] = data_e; ii[1] = idx_e; dn[1] = done_e; bz[1] = busy_e;
            for (int u = 0; u < 2; u++) begin
                if (stall[u]) begin
                    n_checks++;
                    if (vv[u] !== 1'b1 || dd[u] !== pdata[u] || ii[u] !== pidx[u]) begin
                        n_fail++;
                        $display("FAIL %s stall_hold dut%0d: got v=%b idx=%0d data=%h, need v=1 idx=%0d data=%h",
                                 tag, u, vv[u], ii[u], dd[u], pidx[u], pdata[u]);
                    end
                end
                if (vv[u] && first[u] < 0) first[u] = cyc;
                if (dn[u] === 1'b1 && done_cyc[u] < 0) begin
                    done_cyc[u] = cyc;
                    n_checks++;
                    if (bz[u] !== 1'b0 || vv[u] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s done_idle dut%0d: got busy=%b valid=%b, need 0 0",
                                 tag, u, bz[u], vv[u]);
                    end
                end
            end
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int u = 0; u < 2; u++) begin
                if (vv[u] && rk_ready) begin
                    n_checks++;
                    if (beats[u] > 10) begin
                        n_fail++;
                        $display("FAIL %s extra_beat dut%0d: got beat %0d, need at most 11",
                                 tag, u, beats[u] + 1);
                    end else begin
                        exp_idx = (u == 0) ? 10 - beats[u] : beats[u];
                        if (ii[u] !== exp_idx[3:0] || dd[u] !== ref_rk[exp_idx]) begin
                            n_fail++;
                            $display("FAIL %s beat dut%0d #%0d: got idx=%0d data=%h, need idx=%0d data=%h",
                                     tag, u, beats[u], ii[u], dd[u], exp_idx, ref_rk[exp_idx]);
                        end
                        got[u][exp_idx] = dd[u];
                    end
                    beats[u]++;
                end
                stall[u] = vv[u] && !rk_ready;
                pdata[u] = dd[u];
                pidx[u]  = ii[u];
            end
        end
        start = 1'b0;
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (done_cyc[u] < 0) begin
                n_fail++;
                $display("FAIL %s done_timeout dut%0d: got no done in 200 cycles, need done", tag, u);
            end
            n_checks++;
            if (first[u] != exp_lat) begin
                n_fail++;
                $display("FAIL %s first_valid dut%0d: got cycle %0d, need %0d", tag, u, first[u], exp_lat);
            end
            n_checks++;
            if (beats[u] != 11) begin
                n_fail++;
                $display("FAIL %s beat_count dut%0d: got %0d, need 11", tag, u, beats[u]);
            end
            if (!rand_ready) begin
                n_checks++;
                if (done_cyc[u] != exp_lat + 11) begin
                    n_fail++;
                    $display("FAIL %s done_latency dut%0d: got %0d, need %0d",
                             tag, u, done_cyc[u], exp_lat + 11);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (done_d !== 1'b0 || done_e !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse_width: got done=%b/%b, need 0/0", tag, done_d, done_e);
        end
        rk_ready  = 1'b1;
        cache_ok  = 1'b1;
        cache_key = k;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy_d, valid_d, done_d, busy_e, valid_e, done_e} !== 6'b0 ||
            data_d !== '0 || data_e !== '0 || idx_d !== 4'd0 || idx_e !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b/%b valid=%b/%b done=%b/%b idx=%0d/%0d, need all 0",
                     busy_d, busy_e, valid_d, valid_e, done_d, done_e, idx_d, idx_e);
        end
    endtask

    task automatic test_fips_dec();
        run_schedule(K_FIPS, 1'b0, 0, "fips_dec");
        n_checks++;
        if (got[0][10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++;
            $display("FAIL fips_rk10: got %h, need d014f9a8c9ee2589e13f0cc8b6630ca6", got[0][10]);
        end
        n_checks++;
        if (got[0][0] !== K_FIPS) begin
            n_fail++;
            $display("FAIL fips_rk0: got %h, need %h", got[0][0], K_FIPS);
        end
    endtask

    task automatic test_fips_enc();
        run_schedule(K_SEQ, 1'b0, 0, "seq_enc");
        n_checks++;
        if (got[1][10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            n_fail++;
            $display("FAIL seq_rk10: got %h, need 13111d7fe3944a17f307a78b4d2b30c5", got[1][10]);
        end
        n_checks++;
        if (got[1][1] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin
            n_fail++;
            $display("FAIL seq_rk1: got %h, need d6aa74fdd2af72fadaa678f1d6ab76fe", got[1][1]);
        end
    endtask

    task automatic test_backpressure();
        run_schedule(K_FIPS, 1'b1, 0, "backpressure");
        n_checks++;
        if (got[0][9] !== 128'hac7766f319fadc2128d12941575c006e ||
            got[1][9] !== 128'hac7766f319fadc2128d12941575c006e) begin
            n_fail++;
            $display("FAIL bp_rk9: got %h / %h, need ac7766f319fadc2128d12941575c006e",
                     got[0][9], got[1][9]);
        end
    endtask

    task automatic test_repeat_key();
        run_schedule(K_FIPS, 1'b0, 0, "repeat_same");
        run_schedule(K_SEQ,  1'b0, 0, "repeat_diff");
    endtask

    task automatic test_start_ignored();
        run_schedule(K_FIPS, 1'b0, 3, "start_in_expand");
        run_schedule(K_SEQ,  1'b1, 15, "start_in_stream");
    endtask

    task automatic test_abort(input logic [127:0] k, input int abort_cycle);
        start = 1'b1; key = k; rk_ready = 1'b1;
        for (int c = 1; c <= abort_cycle; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        cache_ok = 1'b0;
        #1;
        n_checks++;
        if ({busy_d, valid_d, done_d, busy_e, valid_e, done_e} !== 6'b0) begin
            n_fail++;
            $display("FAIL abort_%0d_outputs: got busy=%b/%b valid=%b/%b done=%b/%b, need all 0",
                     abort_cycle, busy_d, busy_e, valid_d, valid_e, done_d, done_e);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (done_d !== 1'b0 || done_e !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_%0d_no_done: got done=%b/%b, need 0/0", abort_cycle, done_d, done_e);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_schedule(k, 1'b0, 0, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run_schedule(k, n[0], 0, "back_to_back");
        end
    endtask

    initial begin
        build_sbox();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_fips_dec();
        test_fips_enc();
        test_backpressure();
        test_repeat_key();
        test_start_ignored();
        test_abort(K_FIPS, 5);
        test_abort(K_SEQ, 15);
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_128_key_scheduler.md
AES_128_KEY_SCHEDULER -- requirements
Module: aes_128_key_scheduler

Interface
REQ-001 The block SHALL have one parameter: DEC_ORDER, default 1; 1 = stream round keys rk10 down to rk0 (decryption order), 0 = stream rk0 up to rk10.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state is updated on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request expansion of key; sampled only in IDLE.
REQ-005 The block SHALL have port key, input, 128 bits: cipher key, captured in the cycle start is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: high in EXPAND and STREAM.
REQ-007 The block SHALL have port rk_valid, output, 1 bit: round key on rk_data is valid.
REQ-008 The block SHALL have port rk_ready, input, 1 bit: the downstream decryptor accepts the round key.
REQ-009 The block SHALL have port rk_data, output, 128 bits: round key.
REQ-010 The block SHALL have port rk_idx, output, 4 bits: round number (0..10) of rk_data.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last round key is accepted.

Function
REQ-012 The FSM SHALL have states IDLE, EXPAND and STREAM; IDLE->EXPAND on start; EXPAND->STREAM after round 10 is computed; STREAM->IDLE on the final handshake.
REQ-013 EXPAND SHALL compute one FIPS-197 round key per cycle (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36) and store rk0..rk10 in an internal 11x128 register file; EXPAND lasts exactly 10 cycles.
REQ-014 rk0 SHALL equal key; word order SHALL be MSB-first, so key[127:96] is w0.
REQ-015 In STREAM, rk_valid SHALL be high; a beat transfers when rk_valid and rk_ready are both high; rk_data and rk_idx SHALL hold stable while rk_valid is high and rk_ready is low.
REQ-016 STREAM SHALL emit exactly 11 beats, ordered per DEC_ORDER.
REQ-017 done SHALL pulse in the cycle after the 11th transfer, with busy already low in that cycle.
REQ-018 start while busy SHALL be ignored, and key changes during busy SHALL have no effect.
REQ-019 With rk_ready held high, start-to-done latency SHALL be 1 + 10 + 11 cycles.
REQ-020 The register file SHALL retain its contents after STREAM until the next expansion overwrites it.

Reset
REQ-021 While rst_n is low, state SHALL be IDLE and busy, rk_valid and done SHALL be 0; rk_data and rk_idx SHALL be 0.
REQ-022 Assertion of reset mid-EXPAND or mid-STREAM SHALL abort immediately with no done pulse; the register file need not be cleared.

Configuration
REQ-023 When AES_KEY_CACHE_EN is defined, the block SHALL keep the last fully expanded key; a start with an identical key SHALL go IDLE->STREAM directly, skipping EXPAND, for a latency of 1 + 11 cycles.
REQ-024 The cache SHALL be invalidated on reset and by any aborted expansion.
REQ-025 When AES_KEY_CACHE_EN is undefined, every start SHALL run EXPAND and no cache register SHALL be synthesised.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the Rcon table, the round count constant NR=10 and the key width constant.
REQ-027 The S-box SHALL be a sub-module, aes_sbox (8-bit combinational lookup), instantiated 4 times for SubWord.

Verification
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c with DEC_ORDER=1 and rk_ready=1 -> first beat has rk_idx=10 and rk_data d014f9a8c9ee2589e13f0cc8b6630ca6, and the last beat has rk_idx=0 and rk_data equal to the key; done occurs 22 cycles after start.
REQ-029 Key 000102030405060708090a0b0c0d0e0f with DEC_ORDER=0 -> beat rk_idx=10 carries 13111d7fe3944a17f307a78b4d2b30c5; the beat with rk_idx=1 carries d6aa74fdd2af72fadaa678f1d6ab76fe.
REQ-030 Backpressure: rk_ready toggles randomly with the 2b7e... key -> 11 beats in order, rk_data stable while stalled, and rk_idx=9 carries ac7766f319fadc2128d12941575c006e.
REQ-031 start pulsed during EXPAND with a different key -> ignored; the output equals the first key's schedule.
REQ-032 rst_n low at the 5th EXPAND cycle -> busy=0 and rk_valid=0 immediately, no done; a new start then yields the correct schedule.
REQ-033 With AES_KEY_CACHE_EN defined, repeating the same key -> first rk_valid 1 cycle after start; with a different key -> 11 cycles.
